// File: rtl/cpub_stby_agent.sv
// CPUB core standby agent: drains bus traffic, drives standbywfi/standbywfe and stalls wake-up
// until the CRU has re-enabled each core's clock. Define CPUB_DRAIN_TIMEOUT_EN for drain timeout.
module cpub_stby_agent #(
    parameter int unsigned NUM_CORE = 4,
    parameter int unsigned DRAIN_TO = 255,
    parameter int unsigned WAKE_DLY = 4
) (
    input  logic                clk_cpub,
    input  logic                chiprstn,
    input  logic [NUM_CORE-1:0] wfi_req,
    input  logic [NUM_CORE-1:0] wfe_req,
    input  logic [NUM_CORE-1:0] ost_zero,
    input  logic [NUM_CORE-1:0] nIRQ,
    input  logic [NUM_CORE-1:0] nFIQ,
    input  logic                event_i,
    input  logic [NUM_CORE-1:0] core_clk_en,
    input  logic [NUM_CORE-1:0] ncorereset,
    input  logic                err_clr,
    output logic [NUM_CORE-1:0] standbywfi,
    output logic [NUM_CORE-1:0] standbywfe,
    output logic [NUM_CORE-1:0] core_run,
    output logic [NUM_CORE-1:0] drain_err
);

    typedef enum logic [2:0] {
        StRun,
        StDrainWfi,
        StDrainWfe,
        StStbyWfi,
        StStbyWfe,
        StWake
    } state_e;

    localparam logic [3:0] WakeDly = 4'(WAKE_DLY);
`ifdef CPUB_DRAIN_TIMEOUT_EN
    localparam logic [15:0] DrainLast = 16'(DRAIN_TO - 1);
`else
    logic [15:0] unused_drain_to;
    logic        unused_err_clr;
    assign unused_drain_to = 16'(DRAIN_TO);
    assign unused_err_clr  = err_clr;
    assign drain_err       = '0;
`endif

    for (genvar c = 0; c < NUM_CORE; c++) begin : g_core
        state_e     state;
        logic       evt_latch;
        logic [3:0] wake_cnt;
        logic       run_q;
        logic       wfi_q;
        logic       wfe_q;
        logic       wake;
        logic       evt_sets_latch;
`ifdef CPUB_DRAIN_TIMEOUT_EN
        logic [15:0] drain_cnt;
        logic        err_q;
`endif

        assign wake = !nIRQ[c] || !nFIQ[c];
        // WFE-side states consume event_i instead of latching it
        assign evt_sets_latch = event_i &&
                                (state inside {StRun, StDrainWfi, StStbyWfi, StWake});

        always_ff @(posedge clk_cpub or negedge chiprstn) begin
            if (!chiprstn) begin
                state     <= StRun;
                evt_latch <= 1'b0;
                wake_cnt  <= 4'd0;
                run_q     <= 1'b1;
                wfi_q     <= 1'b0;
                wfe_q     <= 1'b0;
`ifdef CPUB_DRAIN_TIMEOUT_EN
                drain_cnt <= 16'd0;
                err_q     <= 1'b0;
`endif
            end else begin
`ifdef CPUB_DRAIN_TIMEOUT_EN
                if (err_clr) err_q <= 1'b0;
`endif
                if (!ncorereset[c]) begin
                    state     <= StRun;
                    evt_latch <= 1'b0;
                    wake_cnt  <= 4'd0;
                    run_q     <= 1'b1;
                    wfi_q     <= 1'b0;
                    wfe_q     <= 1'b0;
`ifdef CPUB_DRAIN_TIMEOUT_EN
                    drain_cnt <= 16'd0;
`endif
                end else begin
                    if (evt_sets_latch) evt_latch <= 1'b1;
                    unique case (state)
                        StRun: begin
                            if (wfi_req[c]) begin
                                state <= StDrainWfi;
                                run_q <= 1'b0;
`ifdef CPUB_DRAIN_TIMEOUT_EN
                                drain_cnt <= 16'd0;
`endif
                            end else if (wfe_req[c]) begin
                                if (evt_latch) begin
                                    evt_latch <= 1'b0;
                                end else begin
                                    state <= StDrainWfe;
                                    run_q <= 1'b0;
`ifdef CPUB_DRAIN_TIMEOUT_EN
                                    drain_cnt <= 16'd0;
`endif
                                end
                            end
                        end
                        StDrainWfi, StDrainWfe: begin
                            if (wake || (state == StDrainWfe && event_i)) begin
                                state <= StRun;
                                run_q <= 1'b1;
                            end else if (ost_zero[c]) begin
                                state <= (state == StDrainWfi) ? StStbyWfi : StStbyWfe;
                                wfi_q <= (state == StDrainWfi);
                                wfe_q <= (state == StDrainWfe);
                            end
`ifdef CPUB_DRAIN_TIMEOUT_EN
                            else if (drain_cnt == DrainLast) begin
                                state <= StRun;
                                run_q <= 1'b1;
                                err_q <= 1'b1;
                            end else begin
                                drain_cnt <= drain_cnt + 16'd1;
                            end
`endif
                        end
                        StStbyWfi, StStbyWfe: begin
                            if (wake || (state == StStbyWfe && event_i)) begin
                                state    <= StWake;
                                wake_cnt <= 4'd0;
                                wfi_q    <= 1'b0;
                                wfe_q    <= 1'b0;
                            end
                        end
                        StWake: begin
                            // Release one cycle after WAKE_DLY consecutive enabled cycles
                            if (wake_cnt == WakeDly) begin
                                state <= StRun;
                                run_q <= 1'b1;
                            end else if (core_clk_en[c]) begin
                                wake_cnt <= wake_cnt + 4'd1;
                            end else begin
                                wake_cnt <= 4'd0;
                            end
                        end
                        default: begin
                            state <= StRun;
                            run_q <= 1'b1;
                            wfi_q <= 1'b0;
                            wfe_q <= 1'b0;
                        end
                    endcase
                end
            end
        end

        assign core_run[c]   = run_q;
        assign standbywfi[c] = wfi_q;
        assign standbywfe[c] = wfe_q;
`ifdef CPUB_DRAIN_TIMEOUT_EN
        assign drain_err[c]  = err_q;
`endif
    end

endmodule

// File: tb/tb_cpub_stby_agent.sv
// Bench for cpub_stby_agent: directed scenarios plus random traffic, all outputs compared
// every cycle against a per-core behavioural model.
module tb_cpub_stby_agent;

    localparam int NC       = 4;
    localparam int DRAIN_TO = 255;
    localparam int WAKE_DLY = 4;
`ifdef CPUB_DRAIN_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif
    localparam int PhRun   = 0;
    localparam int PhDrain = 1;
    localparam int PhStby  = 2;
    localparam int PhWake  = 3;

    logic          clk_cpub = 1'b0;
    logic          chiprstn;
    logic [NC-1:0] wfi_req, wfe_req, ost_zero, nIRQ, nFIQ, core_clk_en, ncorereset;
    logic          event_i, err_clr;
    logic [NC-1:0] standbywfi, standbywfe, core_run, drain_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: phase, standby flavour, event latch, cycles in drain, enable streak, error flag
    int m_ph     [NC];
    bit m_wfe    [NC];
    bit m_latch  [NC];
    int m_age    [NC];
    int m_streak [NC];
    bit m_err    [NC];

    bit gate_pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    always #5 clk_cpub = ~clk_cpub;

    cpub_stby_agent #(
        .NUM_CORE(NC),
        .DRAIN_TO(DRAIN_TO),
        .WAKE_DLY(WAKE_DLY)
    ) dut (
        .clk_cpub   (clk_cpub),
        .chiprstn   (chiprstn),
        .wfi_req    (wfi_req),
        .wfe_req    (wfe_req),
        .ost_zero   (ost_zero),
        .nIRQ       (nIRQ),
        .nFIQ       (nFIQ),
        .event_i    (event_i),
        .core_clk_en(core_clk_en),
        .ncorereset (ncorereset),
        .err_clr    (err_clr),
        .standbywfi (standbywfi),
        .standbywfe (standbywfe),
        .core_run   (core_run),
        .drain_err  (drain_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expected);
        n_checks++;
        if (obs === expected) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, expected);
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_ph[c]     = PhRun;
            m_wfe[c]    = 1'b0;
            m_latch[c]  = 1'b0;
            m_age[c]    = 0;
            m_streak[c] = 0;
            m_err[c]    = 1'b0;
        end
    endtask

    // Applies one clock edge worth of behaviour using the inputs visible at that edge.
    task automatic model_update();
        if (!chiprstn) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NC; c++) begin
            bit wk;
            wk = !nIRQ[c] || !nFIQ[c];
            if (TIMEOUT_EN && err_clr) m_err[c] = 1'b0;
            if (!ncorereset[c]) begin
                m_ph[c]     = PhRun;
                m_latch[c]  = 1'b0;
                m_age[c]    = 0;
                m_streak[c] = 0;
            end else begin
                case (m_ph[c])
                    PhRun: begin
                        if (wfi_req[c]) begin
                            m_ph[c]  = PhDrain;
                            m_wfe[c] = 1'b0;
                            m_age[c] = 0;
                            if (event_i) m_latch[c] = 1'b1;
                        end else if (wfe_req[c]) begin
                            if (m_latch[c]) begin
                                m_latch[c] = 1'b0;
                            end else begin
                                m_ph[c]  = PhDrain;
                                m_wfe[c] = 1'b1;
                                m_age[c] = 0;
                            end
                        end else if (event_i) begin
                            m_latch[c] = 1'b1;
                        end
                    end
                    PhDrain: begin
                        m_age[c]++;
                        if (event_i && !m_wfe[c]) m_latch[c] = 1'b1;
                        if (wk || (event_i && m_wfe[c])) m_ph[c] = PhRun;
                        else if (ost_zero[c]) m_ph[c] = PhStby;
                        else if (TIMEOUT_EN && m_age[c] >= DRAIN_TO) begin
                            m_err[c] = 1'b1;
                            m_ph[c]  = PhRun;
                        end
                    end
                    PhStby: begin
                        if (event_i && !m_wfe[c]) m_latch[c] = 1'b1;
                        if (wk || (event_i && m_wfe[c])) begin
                            m_ph[c]     = PhWake;
                            m_streak[c] = 0;
                        end
                    end
                    default: begin
                        if (event_i) m_latch[c] = 1'b1;
                        if (m_streak[c] >= WAKE_DLY) m_ph[c] = PhRun;
                        else m_streak[c] = core_clk_en[c] ? m_streak[c] + 1 : 0;
                    end
                endcase
            end
        end
    endtask

    task automatic compare_all();
        logic [NC-1:0] er, ei, ee, ex;
        for (int c = 0; c < NC; c++) begin
            er[c] = (m_ph[c] == PhRun);
            ei[c] = (m_ph[c] == PhStby) && !m_wfe[c];
            ee[c] = (m_ph[c] == PhStby) && m_wfe[c];
            ex[c] = m_err[c];
        end
        check("model_core_run", 32'(core_run), 32'(er));
        check("model_standbywfi", 32'(standbywfi), 32'(ei));
        check("model_standbywfe", 32'(standbywfe), 32'(ee));
        check("model_drain_err", 32'(drain_err), 32'(ex));
    endtask

    task automatic step();
        @(posedge clk_cpub);
        model_update();
        @(negedge clk_cpub);
        compare_all();
    endtask

    task automatic idle();
        wfi_req     = '0;
        wfe_req     = '0;
        ost_zero    = '1;
        nIRQ        = '1;
        nFIQ        = '1;
        event_i     = 1'b0;
        core_clk_en = '1;
        ncorereset  = '1;
        err_clr     = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_core_run"}, 32'(core_run), 32'hF);
        check({tag, "_standbywfi"}, 32'(standbywfi), 32'h0);
        check({tag, "_standbywfe"}, 32'(standbywfe), 32'h0);
        check({tag, "_drain_err"}, 32'(drain_err), 32'h0);
    endtask

    initial begin
        chiprstn = 1'b0;
        idle();
        model_reset();
        #12;
        check_reset_values("reset");
        @(negedge clk_cpub);
        chiprstn = 1'b1;
        step();

        // WFI with bus already idle, IRQ after 10 cycles
        wfi_req[0] = 1'b1; step(); wfi_req[0] = 1'b0;
        check("wfi_drain_run", 32'(core_run[0]), 0);
        check("wfi_drain_sb", 32'(standbywfi[0]), 0);
        step();
        check("wfi_sb", 32'(standbywfi[0]), 1);
        repeat (8) step();
        nIRQ[0] = 1'b0; step(); nIRQ[0] = 1'b1;
        check("wfi_sb_drop", 32'(standbywfi[0]), 0);
        for (int k = 1; k <= WAKE_DLY + 1; k++) begin
            step();
            check("wfi_wake_run", 32'(core_run[0]), 32'(k == WAKE_DLY + 1));
        end

        // WFE consumes a pending event, then a second WFE sleeps until SEV
        event_i = 1'b1; step(); event_i = 1'b0;
        wfe_req[1] = 1'b1; step(); wfe_req[1] = 1'b0;
        check("wfe_latched_run", 32'(core_run[1]), 1);
        check("wfe_latched_sb", 32'(standbywfe[1]), 0);
        wfe_req[1] = 1'b1; step(); wfe_req[1] = 1'b0;
        step();
        check("wfe_sb", 32'(standbywfe[1]), 1);
        check("wfe_sb_not_wfi", 32'(standbywfi[1]), 0);
        event_i = 1'b1; step(); event_i = 1'b0;
        check("wfe_evt_wake", 32'(standbywfe[1]), 0);
        repeat (WAKE_DLY + 1) step();
        check("wfe_run", 32'(core_run[1]), 1);

        // Drain aborted by FIQ
        ost_zero[2] = 1'b0;
        wfi_req[2] = 1'b1; step(); wfi_req[2] = 1'b0;
        repeat (4) step();
        nFIQ[2] = 1'b0; step(); nFIQ[2] = 1'b1;
        check("abort_run", 32'(core_run[2]), 1);
        check("abort_sb", 32'(standbywfi[2]), 0);

        // Drain timeout on cores 0 and 2
        ost_zero = 4'b1010;
        wfi_req  = 4'b0101; step(); wfi_req = '0;
        for (int k = 1; k <= DRAIN_TO; k++) begin
            step();
            if (k == DRAIN_TO - 1) check("to_pre_err", 32'(drain_err[2]), 0);
        end
        check("to_err", 32'(drain_err[2]), 32'(TIMEOUT_EN));
        check("to_run", 32'(core_run[2]), 32'(TIMEOUT_EN));
        if (!TIMEOUT_EN) begin
            repeat (50) step();
            nIRQ = 4'b1010; step(); nIRQ = '1;
        end
        ost_zero = '1;

        // Per-core soft reset while in standby keeps the sticky error
        wfi_req[0] = 1'b1; step(); wfi_req[0] = 1'b0;
        step();
        check("crst_pre_sb", 32'(standbywfi[0]), 1);
        ncorereset[0] = 1'b0; step(); ncorereset[0] = 1'b1;
        check("crst_sb", 32'(standbywfi[0]), 0);
        check("crst_run", 32'(core_run[0]), 1);
        check("crst_err", 32'(drain_err[0]), 32'(TIMEOUT_EN));
        err_clr = 1'b1; step(); err_clr = 1'b0;
        check("err_clr", 32'(drain_err), 0);

        // Wake stall with a gap in the returned clock enable
        wfi_req[3] = 1'b1; step(); wfi_req[3] = 1'b0;
        step();
        nIRQ[3] = 1'b0; step(); nIRQ[3] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            core_clk_en[3] = gate_pat[k];
            step();
            check("gate_hold", 32'(core_run[3]), 0);
        end
        core_clk_en[3] = 1'b1;
        step();
        check("gate_release", 32'(core_run[3]), 1);

        // WFI and WFE together: WFI wins and the latch survives
        event_i = 1'b1; step(); event_i = 1'b0;
        wfi_req[0] = 1'b1; wfe_req[0] = 1'b1; step();
        wfi_req[0] = 1'b0; wfe_req[0] = 1'b0;
        step();
        check("sim_wfi", 32'(standbywfi[0]), 1);
        check("sim_not_wfe", 32'(standbywfe[0]), 0);
        nIRQ[0] = 1'b0; step(); nIRQ[0] = 1'b1;
        repeat (WAKE_DLY + 1) step();
        check("sim_run", 32'(core_run[0]), 1);
        wfe_req[0] = 1'b1; step(); wfe_req[0] = 1'b0;
        check("sim_latch_kept", 32'(core_run[0]), 1);
        step();
        check("sim_latch_wfe", 32'(standbywfe[0]), 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NC; c++) begin
                wfi_req[c]     = ($urandom_range(0, 11) == 0);
                wfe_req[c]     = ($urandom_range(0, 9) == 0);
                ost_zero[c]    = ($urandom_range(0, 2) == 0);
                nIRQ[c]        = ($urandom_range(0, 13) != 0);
                nFIQ[c]        = ($urandom_range(0, 19) != 0);
                core_clk_en[c] = ($urandom_range(0, 4) != 0);
                ncorereset[c]  = ($urandom_range(0, 59) != 0);
            end
            event_i = ($urandom_range(0, 11) == 0) && (wfe_req == '0);
            err_clr = ($urandom_range(0, 29) == 0);
            step();
        end

        // Asynchronous chip reset mid-cycle
        idle();
        wfi_req = '1; step(); wfi_req = '0;
        step();
        #2;
        chiprstn = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        step();
        chiprstn = 1'b1;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpub_stby_agent.md
Name: cpub_stby_agent

Overview:
- Core-side low-power handshake agent for the CPUB subsystem, one instance serving NUM_CORE cores.
- Converts per-core WFI/WFE execution requests into the standbywfi/standbywfe levels the CPUB clock/reset unit consumes. Before asserting either level it drains outstanding bus traffic.
- Detects wake events (nIRQ, nFIQ, SEV) and holds the core stalled until the CRU has re-enabled that core's clock.
- Runs on the free-running CPUB clock, not the gated core clock.

Parameters:
NUM_CORE, 4, number of cores; every per-core port is NUM_CORE bits wide.
DRAIN_TO, 255, drain timeout in cycles; range 1..65535.
WAKE_DLY, 4, consecutive cycles core_clk_en must be high before the core is released; range 1..15.

Ports:
clk_cpub  input  1  free-running CPUB clock
chiprstn  input  1  async active-low reset
wfi_req  input  NUM_CORE  1-cycle pulse: core executed WFI
wfe_req  input  NUM_CORE  1-cycle pulse: core executed WFE
ost_zero  input  NUM_CORE  level: no outstanding bus transactions
nIRQ  input  NUM_CORE  active-low IRQ, level
nFIQ  input  NUM_CORE  active-low FIQ, level
event_i  input  1  SEV broadcast pulse
core_clk_en  input  NUM_CORE  per-core clock enable returned by CRU
ncorereset  input  NUM_CORE  per-core soft reset, active low, synchronous to clk_cpub
err_clr  input  1  pulse: clears drain_err
standbywfi  output  NUM_CORE  core is in WFI standby
standbywfe  output  NUM_CORE  core is in WFE standby
core_run  output  NUM_CORE  core may execute
drain_err  output  NUM_CORE  sticky: drain timed out

Behaviour:
- Clock and reset: one clock, clk_cpub. chiprstn is asynchronous, active-low.
- Reset values (chiprstn low): state RUN, core_run=1, standbywfi=0, standbywfe=0, drain_err=0. Event latch and counters cleared.
- All outputs are registered. Each core has an independent FSM.
- wake = !nIRQ | !nFIQ, sampled each cycle.
- RUN (core_run=1):
  - wfi_req → DRAIN, mode=WFI.
  - wfe_req with event latch set → clear latch, stay RUN.
  - wfe_req with latch clear → DRAIN, mode=WFE.
  - wfi_req and wfe_req in the same cycle: WFI wins, event latch untouched.
- DRAIN (core_run=0, standby outputs 0):
  - Counter increments every cycle.
  - wake, or (mode=WFE and event_i) → RUN next cycle. Abort; standby never asserted; for WFE the event is consumed.
  - Otherwise ost_zero → STBY_WFI or STBY_WFE per mode. Standby asserts the cycle after ost_zero is sampled high.
  - Counter reaching DRAIN_TO → set drain_err, go RUN.
  - Priority: abort > ost_zero > timeout.
- STBY_WFI: standbywfi=1. wake → WAKE.
- STBY_WFE: standbywfe=1. wake or event_i → WAKE; event_i here is consumed and does not set the latch.
- WAKE:
  - Standby outputs drop on entry, i.e. one cycle after the wake sample.
  - Counter counts consecutive cycles with core_clk_en=1; it resets to 0 on any cycle with core_clk_en=0.
  - Count reaching WAKE_DLY → RUN, core_run=1 on the following cycle.
  - Minimum wake latency from interrupt to core_run=1 is WAKE_DLY+1 cycles.
- Event latch: event_i sets the latch for every core in RUN, DRAIN(WFI), STBY_WFI or WAKE. It stays set until consumed by a WFE.
- ncorereset low (per core, synchronous, any state): next cycle state=RUN, core_run=1, standby=0, counters=0, event latch cleared. drain_err is preserved.
- drain_err:
  - Cleared only by chiprstn or err_clr.
  - When set and err_clr coincide, set wins.
- standbywfi and standbywfe are never both 1 for the same core.

Optional Feature:
- Macro CPUB_DRAIN_TIMEOUT_EN.
- Defined: DRAIN timeout behaves as specified above.
- Undefined:
  - DRAIN waits indefinitely for ost_zero or abort.
  - drain_err is tied 0; err_clr is ignored.
  - The drain counter logic is removed. The WAKE counter remains.

Test Plan:
- WFI basic:
  - Stimulus: core0 wfi_req with ost_zero=1, then nIRQ[0]=0 after 10 cycles, core_clk_en[0]=1 throughout.
  - Required: standbywfi[0]=1 two cycles after wfi_req; it drops one cycle after the IRQ is sampled; core_run[0]=1 exactly WAKE_DLY+1 = 5 cycles after the IRQ sample.
- WFE with pending event:
  - Stimulus: event_i pulse in RUN, then wfe_req[1].
  - Required: core1 stays RUN, core_run stays 1, standbywfe[1] never asserts, latch clears. A second wfe_req reaches STBY_WFE, and an event_i pulse wakes it.
- Drain abort and timeout:
  - Stimulus: ost_zero[2]=0, wfi_req[2], then nFIQ[2]=0 at cycle 5.
  - Required: RUN at cycle 6 with no standby.
  - Stimulus: repeat without FIQ and with DRAIN_TO=255.
  - Required: drain_err[2]=1 after 255 cycles, core_run=1. err_clr clears it.
- Wake clock gating:
  - Stimulus: in WAKE, core_clk_en[3] pattern 1,1,0,1,1,1,1.
  - Required: core_run[3] rises only after the final four consecutive 1s.
- Reset mid-operation:
  - Stimulus: ncorereset[0]=0 while core0 is in STBY_WFI with drain_err[0]=1.
  - Required: next cycle standbywfi[0]=0, core_run[0]=1, drain_err[0] still 1.
  - Stimulus: chiprstn low asynchronously.
  - Required: all outputs reach reset values immediately, without waiting for a clock edge.
- Simultaneous requests:
  - Stimulus: wfi_req[0] and wfe_req[0] in the same cycle, with the event latch set.
  - Required: WFI path taken, standbywfi[0] asserts, latch still set afterwards.
